// File: rtl/huffman_pkg.sv
// Shared constants, writedata field positions and table entry layout for the Huffman coder.
package huffman_pkg;

    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned CODE_W   = 8;
    localparam int unsigned LEN_W    = 4;
    localparam int unsigned OUT_W    = 32;
    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam int unsigned ACC_W    = 40;
    localparam int unsigned CNT_W    = 6;

    localparam int unsigned FIN_BIT  = 6;
    localparam int unsigned LEN_LSB  = 6;
    localparam int unsigned CODE_LSB = 10;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [LEN_W-1:0]  len;
    } entry_t;

    // Codes never exceed CODE_W bits, so longer requested lengths saturate.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : l;
    endfunction

endpackage

// File: rtl/huffman_coder_avalon_if.sv
// Avalon-MM slave bus bundle for the Huffman coder.
interface huffman_coder_avalon_if;
    import huffman_pkg::*;

    logic [OUT_W-1:0] writedata;
    logic [OUT_W-1:0] readdata;
    logic             write;
    logic             read;
    logic             chipselect;

    modport slave  (input writedata, write, read, chipselect, output readdata);
    modport master (output writedata, write, read, chipselect, input readdata);

endinterface

// File: rtl/huffman_bit_packer.sv
// MSB-first bit accumulator: emits 32-bit words when full and flushes the tail on finalize.
module huffman_bit_packer
    import huffman_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              app_vld_i,
    input  logic              app_fin_i,
    input  logic [CODE_W-1:0] app_code_i,
    input  logic [LEN_W-1:0]  app_len_i,
    output logic [OUT_W-1:0]  encoded_o,
    output logic [CNT_W-1:0]  length_o,
    output logic              enable_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int unsigned MASK_W = CODE_W + 1;
    localparam int unsigned PAD_W  = ACC_W - CODE_W;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pend_q, pend_d;
    logic [OUT_W-1:0]  enc_q, enc_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic              en_q, en_d;

    logic [LEN_W-1:0]  eff_len;
    logic [CODE_W-1:0] masked;
    logic [ACC_W-1:0]  aligned, base_acc, merged;
    logic [CNT_W-1:0]  base_cnt, total;
    logic              fin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
            enc_q   <= '0;
            len_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            enc_q   <= enc_d;
            len_q   <= len_d;
            en_q    <= en_d;
        end
    end

    // A pending flush drains the old tail this cycle, so the new code starts an empty accumulator.
    always_comb begin
        eff_len  = app_vld_i ? app_len_i : '0;
        fin      = app_vld_i & app_fin_i;
        masked   = CODE_W'((MASK_W'(1) << eff_len) - MASK_W'(1)) & app_code_i;
        aligned  = {masked, {PAD_W{1'b0}}} << (LEN_W'(CODE_W) - eff_len);
        base_acc = pend_q ? '0 : acc_q;
        base_cnt = pend_q ? '0 : count_q;
        merged   = base_acc | (aligned >> base_cnt);
        total    = base_cnt + CNT_W'(eff_len);

        acc_d    = merged;
        count_d  = total;
        pend_d   = 1'b0;
        enc_d    = enc_q;
        len_d    = len_q;
        en_d     = 1'b0;

        if (pend_q) begin
            en_d  = 1'b1;
            enc_d = acc_q[ACC_W-1 -: OUT_W];
            len_d = count_q;
            if (fin && (total != '0)) pend_d = 1'b1;
        end else if (total >= CNT_W'(OUT_W)) begin
            en_d    = 1'b1;
            enc_d   = merged[ACC_W-1 -: OUT_W];
            len_d   = CNT_W'(OUT_W);
            acc_d   = merged << OUT_W;
            count_d = total - CNT_W'(OUT_W);
            if (fin && (count_d != '0)) pend_d = 1'b1;
        end else if (fin && (total != '0)) begin
            en_d    = 1'b1;
            enc_d   = merged[ACC_W-1 -: OUT_W];
            len_d   = total;
            acc_d   = '0;
            count_d = '0;
        end
    end

    assign encoded_o = enc_q;
    assign length_o  = len_q;
    assign enable_o  = en_q;
    assign count_o   = count_q;

endmodule

// File: rtl/huffman_coder_avalon.sv
// Avalon-MM Huffman coder: code table plus bus decode feeding the bit packer.
// Define HUFF_READBACK_EN to return the looked-up entry on readdata instead of the bit count.
module huffman_coder_avalon
    import huffman_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    huffman_coder_avalon_if.slave  bus,
    output logic [OUT_W-1:0]       encoded_out_o,
    output logic [CNT_W-1:0]       length_out_o,
    output logic                   enable_out_o
);

    entry_t             tbl_q [DEPTH];
    entry_t             rd_ent_q;
    logic               rd_vld_q;
    logic               rd_fin_q;
    logic [OUT_W-1:0]   readdata_q;
    logic [CNT_W-1:0]   pk_count;
    logic               wr_c;
    logic               rd_c;
    logic [ADDR_W-1:0]  addr_c;
    logic               unused_wd;

    // A simultaneous write takes priority and suppresses the read.
    assign wr_c   = bus.chipselect & bus.write;
    assign rd_c   = bus.chipselect & bus.read & ~bus.write;
    assign addr_c = bus.writedata[ADDR_W-1:0];
    assign unused_wd = ^bus.writedata[OUT_W-1:CODE_LSB+CODE_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) tbl_q[i] <= '0;
        end else if (wr_c) begin
            tbl_q[addr_c] <= '{code: bus.writedata[CODE_LSB +: CODE_W],
                               len:  clamp_len(bus.writedata[LEN_LSB +: LEN_W])};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q   <= 1'b0;
            rd_fin_q   <= 1'b0;
            rd_ent_q   <= '0;
            readdata_q <= '0;
        end else begin
            rd_vld_q <= rd_c;
            rd_fin_q <= rd_c & bus.writedata[FIN_BIT];
            if (rd_c) begin
                rd_ent_q <= tbl_q[addr_c];
`ifdef HUFF_READBACK_EN
                readdata_q <= {14'b0, tbl_q[addr_c], addr_c};
`else
                readdata_q <= {26'b0, pk_count};
`endif
            end
        end
    end

    assign bus.readdata = readdata_q;

    huffman_bit_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .app_vld_i  (rd_vld_q),
        .app_fin_i  (rd_fin_q),
        .app_code_i (rd_ent_q.code),
        .app_len_i  (rd_ent_q.len),
        .encoded_o  (encoded_out_o),
        .length_o   (length_out_o),
        .enable_o   (enable_out_o),
        .count_o    (pk_count)
    );

endmodule

// File: tb/tb_huffman_coder_avalon.sv
// Directed, table-driven bench for huffman_coder_avalon with hand-computed packed words.
module tb_huffman_coder_avalon;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] encoded_out_o;
    logic [5:0]  length_out_o;
    logic        enable_out_o;
    int          cyc = 0;
    int          last_rd_cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] enc;
        logic [5:0]  len;
        int          cyc;
    } pulse_t;

    typedef struct {
        string       name;
        logic [5:0]  addr;
        logic [7:0]  code;
        logic [3:0]  wlen;
        int          nrd;
        logic        fin;
        int          exp_n;
        logic [31:0] exp_enc0;
        logic [5:0]  exp_len0;
        logic [31:0] exp_enc;
        logic [5:0]  exp_len;
    } vec_t;

    pulse_t pulses[$];
    vec_t   vecs[7];

    huffman_coder_avalon_if bus ();

    huffman_coder_avalon dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .encoded_out_o (encoded_out_o),
        .length_out_o  (length_out_o),
        .enable_out_o  (enable_out_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (!rst && enable_out_o)
            pulses.push_back('{encoded_out_o, length_out_o, cyc});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input logic cs, input logic w, input logic r, input logic [31:0] wd);
        @(negedge clk);
        bus.chipselect = cs;
        bus.write      = w;
        bus.read       = r;
        bus.writedata  = wd;
    endtask

    task automatic idle(input int n);
        repeat (n) access(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] c, input logic [3:0] l);
        access(1'b1, 1'b1, 1'b0, {14'b0, c, l, a});
    endtask

    task automatic rd(input logic [5:0] a, input logic f);
        access(1'b1, 1'b0, 1'b1, {25'b0, f, a});
        last_rd_cyc = cyc;
    endtask

    task automatic chk_pulse(input string name, input int idx, input logic [31:0] enc,
                             input logic [5:0] len, input int at_cyc);
        if (idx < pulses.size()) begin
            chk({name, ".enc"}, pulses[idx].enc, enc);
            chk({name, ".len"}, 32'(pulses[idx].len), 32'(len));
            chk({name, ".cyc"}, 32'(pulses[idx].cyc), 32'(at_cyc));
        end else begin
            chk({name, ".present"}, 32'(pulses.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        vecs[0] = '{"four_bytes",  6'd1, 8'h01, 4'd8,  4, 1'b0, 1, 32'h01010101, 6'd32, 32'h01010101, 6'd32};
        vecs[1] = '{"nibble_fin",  6'd2, 8'h02, 4'd4,  2, 1'b1, 1, 32'h22000000, 6'd8,  32'h22000000, 6'd8};
        vecs[2] = '{"len_clamp",   6'd3, 8'hFF, 4'd15, 1, 1'b1, 1, 32'hFF000000, 6'd8,  32'hFF000000, 6'd8};
        vecs[3] = '{"mask_hi",     6'd4, 8'hA5, 4'd3,  3, 1'b1, 1, 32'hB6800000, 6'd9,  32'hB6800000, 6'd9};
        vecs[4] = '{"len_zero",    6'd5, 8'h7E, 4'd0,  2, 1'b1, 0, 32'h0,        6'd0,  32'h0,        6'd0};
        vecs[5] = '{"thirty_bits", 6'd6, 8'h3C, 4'd6,  5, 1'b1, 1, 32'hF3CF3CF0, 6'd30, 32'hF3CF3CF0, 6'd30};
        vecs[6] = '{"forty_bits",  6'd7, 8'h81, 4'd8,  5, 1'b1, 2, 32'h81818181, 6'd32, 32'h81000000, 6'd8};

        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.writedata  = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: nothing emitted, outputs at zero.
        idle(10);
        chk("reset.pulses", 32'(pulses.size()), 32'd0);
        chk("reset.enc", encoded_out_o, 32'h0);
        chk("reset.len", 32'(length_out_o), 32'd0);
        chk("reset.rdata", bus.readdata, 32'h0);

        foreach (vecs[v]) begin
            pulses.delete();
            wr(vecs[v].addr, vecs[v].code, vecs[v].wlen);
            for (int i = 0; i < vecs[v].nrd; i++)
                rd(vecs[v].addr, vecs[v].fin && (i == vecs[v].nrd - 1));
            idle(6);
            chk({vecs[v].name, ".count"}, 32'(pulses.size()), 32'(vecs[v].exp_n));
            if (vecs[v].exp_n > 0) begin
                chk({vecs[v].name, ".enc0"}, pulses[0].enc, vecs[v].exp_enc0);
                chk({vecs[v].name, ".len0"}, 32'(pulses[0].len), 32'(vecs[v].exp_len0));
                chk({vecs[v].name, ".enc"}, pulses[pulses.size()-1].enc, vecs[v].exp_enc);
                chk({vecs[v].name, ".len"}, 32'(pulses[pulses.size()-1].len), 32'(vecs[v].exp_len));
                chk({vecs[v].name, ".lat"}, 32'(pulses[pulses.size()-1].cyc), 32'(last_rd_cyc + 2));
            end
        end

        // 31 bits queued, finalize with an 8-bit code, then a new finalize during the pending cycle.
        pulses.delete();
        wr(6'd11, 8'h55, 4'd7);
        wr(6'd12, 8'hFF, 4'd8);
        rd(6'd1, 1'b0);
        rd(6'd1, 1'b0);
        rd(6'd1, 1'b0);
        rd(6'd11, 1'b0);
        rd(6'd12, 1'b1);
        begin
            int base;
            base = last_rd_cyc + 2;
            rd(6'd2, 1'b1);
            idle(6);
            chk("overflow.count", 32'(pulses.size()), 32'd3);
            chk_pulse("overflow.full", 0, 32'h010101AB, 6'd32, base);
            chk_pulse("overflow.rem", 1, 32'hFE000000, 6'd7, base + 1);
            chk_pulse("overflow.next", 2, 32'h20000000, 6'd4, base + 2);
        end

        // Write with read in the same cycle, then deselected accesses.
        pulses.delete();
        access(1'b1, 1'b1, 1'b1, {14'b0, 8'hC3, 4'd8, 6'd20});
        access(1'b0, 1'b1, 1'b0, {14'b0, 8'h11, 4'd8, 6'd20});
        access(1'b0, 1'b0, 1'b1, {25'b0, 1'b1, 6'd20});
        idle(6);
        chk("wr_rd.no_append", 32'(pulses.size()), 32'd0);
        rd(6'd20, 1'b1);
        idle(5);
        chk("wr_rd.count", 32'(pulses.size()), 32'd1);
        chk_pulse("wr_rd.entry", 0, 32'hC3000000, 6'd8, last_rd_cyc + 2);

        // 12 bits pending, then reset discards them.
        pulses.delete();
        rd(6'd2, 1'b0);
        rd(6'd2, 1'b0);
        rd(6'd2, 1'b0);
        idle(3);
        rd(6'd63, 1'b0);
        idle(1);
`ifdef HUFF_READBACK_EN
        chk("rdata.readback", bus.readdata, 32'd63);
`else
        chk("rdata.count", bus.readdata, 32'd12);
`endif
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        chk("rst.enable", 32'(enable_out_o), 32'd0);
        chk("rst.enc", encoded_out_o, 32'h0);
        chk("rst.rdata", bus.readdata, 32'h0);
        rst = 1'b0;
        idle(2);
        rd(6'd2, 1'b1);
        idle(4);
        chk("rst.table_cleared", 32'(pulses.size()), 32'd0);
        wr(6'd2, 8'h02, 4'd4);
        rd(6'd2, 1'b1);
        idle(5);
        chk("rst.count", 32'(pulses.size()), 32'd1);
        chk_pulse("rst.flush", 0, 32'h20000000, 6'd4, last_rd_cyc + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
